// File: rtl/sipo_frame_ctrl_if.sv
// Frame-controller port bundle: frame control, serial input, parallel word
// handshake and overrun status.
interface sipo_frame_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             abort;
  logic             din;
  logic             din_valid;
  logic             busy;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             q_ready;
  logic             overrun;
  logic             ovr_clr;

  modport master (
    output start, abort, din, din_valid, q_ready, ovr_clr,
    input  busy, q, q_valid, overrun
  );

  modport slave (
    input  start, abort, din, din_valid, q_ready, ovr_clr,
    output busy, q, q_valid, overrun
  );
endinterface

// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out frame controller: assembles WIDTH qualified serial
// bits into a word and offers it on a valid/ready port with sticky overrun.
module sipo_frame_ctrl #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  sipo_frame_ctrl_if.slave  frm_if
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] shift_s;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state, shift and output-slot logic
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    overrun_d = overrun_q;

    if (MSB_FIRST) begin
      shift_s = {sr_q[WIDTH-2:0], frm_if.din};
    end else begin
      shift_s = {frm_if.din, sr_q[WIDTH-1:1]};
    end

    if (q_valid_q && frm_if.q_ready) begin
      q_valid_d = 1'b0;
    end else begin
      q_valid_d = q_valid_q;
    end

    // Clear first so a drop on the same edge overrides it
    if (frm_if.ovr_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      IDLE: begin
        if (frm_if.abort) begin
          state_d = IDLE;
        end else if (frm_if.start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sr_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (frm_if.abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          sr_d    = '0;
        end else if (frm_if.din_valid) begin
          sr_d = shift_s;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (!q_valid_q || frm_if.q_ready) begin
              q_d       = shift_s;
              q_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign frm_if.busy    = (state_q == SHIFT);
  assign frm_if.q       = q_q;
  assign frm_if.q_valid = q_valid_q;
  assign frm_if.overrun = overrun_q;
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Scoreboard bench for sipo_frame_ctrl: an MSB-first and an LSB-first instance.
module tb_sipo_frame_ctrl;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  logic [3:0] exp_q0[$];
  logic [3:0] exp_q1[$];

  sipo_frame_ctrl_if #(.WIDTH(4)) m_if ();
  sipo_frame_ctrl_if #(.WIDTH(4)) l_if ();

  sipo_frame_ctrl #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk    (clk),
    .rst    (rst),
    .frm_if (m_if.slave)
  );

  sipo_frame_ctrl #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk    (clk),
    .rst    (rst),
    .frm_if (l_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit sel, input logic st, input logic dv, input logic d);
    if (sel) begin
      l_if.start = st; l_if.din_valid = dv; l_if.din = d;
    end else begin
      m_if.start = st; m_if.din_valid = dv; m_if.din = d;
    end
  endtask

  // Bits are sent w[3] first; rdy_last raises q_ready just before the last bit edge
  task automatic run_frame(input bit sel, input logic [3:0] w, input bit gaps,
                           input bit dv_on_start, input bit rdy_last);
    drv(sel, 1'b1, dv_on_start, ~w[3]);
    step();
    for (int i = 3; i >= 0; i--) begin
      if (i == 0 && rdy_last) m_if.q_ready = 1'b1;
      drv(sel, 1'b0, 1'b1, w[i]);
      step();
      if (gaps && i != 0) begin
        drv(sel, 1'b0, 1'b0, ~w[i]);
        step();
      end
    end
    drv(sel, 1'b0, 1'b0, 1'b0);
  endtask

  // Scoreboard: compare each word at the edge that will consume it
  always @(negedge clk) begin
    if (!rst && m_if.q_valid && m_if.q_ready) begin
      if (exp_q0.size() == 0) check_val("sb_msb_unexpected", {28'd0, m_if.q}, 32'hFFFF_FFFF);
      else check_val("sb_msb_word", {28'd0, m_if.q}, {28'd0, exp_q0.pop_front()});
    end
    if (!rst && l_if.q_valid && l_if.q_ready) begin
      if (exp_q1.size() == 0) check_val("sb_lsb_unexpected", {28'd0, l_if.q}, 32'hFFFF_FFFF);
      else check_val("sb_lsb_word", {28'd0, l_if.q}, {28'd0, exp_q1.pop_front()});
    end
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    m_if.start = 1'b0; m_if.abort = 1'b0; m_if.din = 1'b0; m_if.din_valid = 1'b0;
    m_if.q_ready = 1'b1; m_if.ovr_clr = 1'b0;
    l_if.start = 1'b0; l_if.abort = 1'b0; l_if.din = 1'b0; l_if.din_valid = 1'b0;
    l_if.q_ready = 1'b1; l_if.ovr_clr = 1'b0;
    step();
    step();
    check_val("rst_busy", {31'd0, m_if.busy}, 32'd0);
    check_val("rst_qv", {31'd0, m_if.q_valid}, 32'd0);
    check_val("rst_q", {28'd0, m_if.q}, 32'd0);
    check_val("rst_ovr", {31'd0, m_if.overrun}, 32'd0);
    rst = 1'b0;
    step();

    // 1: asynchronous reset in the middle of a frame
    drv(1'b0, 1'b1, 1'b0, 1'b0); step();
    drv(1'b0, 1'b0, 1'b1, 1'b1); step();
    drv(1'b0, 1'b0, 1'b1, 1'b1); step();
    drv(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("t1_busy_mid", {31'd0, m_if.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_val("t1_busy_rst", {31'd0, m_if.busy}, 32'd0);
    check_val("t1_qv_rst", {31'd0, m_if.q_valid}, 32'd0);
    check_val("t1_q_rst", {28'd0, m_if.q}, 32'd0);
    check_val("t1_ovr_rst", {31'd0, m_if.overrun}, 32'd0);
    #1;
    rst = 1'b0;
    step();
    exp_q0.push_back(4'b1001);
    run_frame(1'b0, 4'b1001, 1'b0, 1'b0, 1'b0);
    check_val("t1_q", {28'd0, m_if.q}, 32'h9);
    step();

    // 2: back-to-back bits, one-cycle valid pulse
    exp_q0.push_back(4'b0111);
    run_frame(1'b0, 4'b0111, 1'b0, 1'b0, 1'b0);
    check_val("t2_q", {28'd0, m_if.q}, 32'h7);
    check_val("t2_qv", {31'd0, m_if.q_valid}, 32'd1);
    check_val("t2_busy", {31'd0, m_if.busy}, 32'd0);
    step();
    check_val("t2_qv_drop", {31'd0, m_if.q_valid}, 32'd0);

    // 3: gaps, and a valid bit on the start cycle that must be ignored
    exp_q0.push_back(4'b1011);
    run_frame(1'b0, 4'b1011, 1'b1, 1'b1, 1'b0);
    check_val("t3_q", {28'd0, m_if.q}, 32'hB);
    step();

    // 4: backpressure, overrun and clear priority
    m_if.q_ready = 1'b0;
    exp_q0.push_back(4'b0111);
    run_frame(1'b0, 4'b0111, 1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 4'b1010, 1'b0, 1'b0, 1'b0);
    check_val("t4_q_hold", {28'd0, m_if.q}, 32'h7);
    check_val("t4_qv_hold", {31'd0, m_if.q_valid}, 32'd1);
    check_val("t4_ovr_set", {31'd0, m_if.overrun}, 32'd1);
    m_if.q_ready = 1'b1;
    step();
    m_if.q_ready = 1'b0;
    check_val("t4_qv_drain", {31'd0, m_if.q_valid}, 32'd0);
    m_if.ovr_clr = 1'b1;
    step();
    m_if.ovr_clr = 1'b0;
    check_val("t4_ovr_clr", {31'd0, m_if.overrun}, 32'd0);
    exp_q0.push_back(4'b0011);
    run_frame(1'b0, 4'b0011, 1'b0, 1'b0, 1'b0);
    m_if.ovr_clr = 1'b1;
    run_frame(1'b0, 4'b0101, 1'b0, 1'b0, 1'b0);
    m_if.ovr_clr = 1'b0;
    check_val("t4_ovr_set_wins", {31'd0, m_if.overrun}, 32'd1);
    m_if.q_ready = 1'b1;
    m_if.ovr_clr = 1'b1;
    step();
    m_if.ovr_clr = 1'b0;
    check_val("t4_ovr_clr2", {31'd0, m_if.overrun}, 32'd0);

    // 5: drain and load on the same edge
    m_if.q_ready = 1'b0;
    exp_q0.push_back(4'b0111);
    run_frame(1'b0, 4'b0111, 1'b0, 1'b0, 1'b0);
    exp_q0.push_back(4'b1100);
    run_frame(1'b0, 4'b1100, 1'b0, 1'b0, 1'b1);
    check_val("t5_q", {28'd0, m_if.q}, 32'hC);
    check_val("t5_qv", {31'd0, m_if.q_valid}, 32'd1);
    check_val("t5_ovr", {31'd0, m_if.overrun}, 32'd0);
    step();

    // 6: abort mid-frame, abort beats start in IDLE, then LSB-first
    drv(1'b0, 1'b1, 1'b0, 1'b0); step();
    drv(1'b0, 1'b0, 1'b1, 1'b1); step();
    drv(1'b0, 1'b0, 1'b1, 1'b0); step();
    m_if.abort = 1'b1;
    drv(1'b0, 1'b0, 1'b1, 1'b1); step();
    m_if.abort = 1'b0;
    drv(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("t6_busy_abort", {31'd0, m_if.busy}, 32'd0);
    check_val("t6_qv_abort", {31'd0, m_if.q_valid}, 32'd0);
    exp_q0.push_back(4'b1100);
    run_frame(1'b0, 4'b1100, 1'b0, 1'b0, 1'b0);
    check_val("t6_q", {28'd0, m_if.q}, 32'hC);
    step();
    m_if.abort = 1'b1;
    drv(1'b0, 1'b1, 1'b0, 1'b0); step();
    m_if.abort = 1'b0;
    drv(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("t6_abort_start", {31'd0, m_if.busy}, 32'd0);
    exp_q1.push_back(4'b1110);
    run_frame(1'b1, 4'b0111, 1'b0, 1'b0, 1'b0);
    check_val("t6_lsb_q", {28'd0, l_if.q}, 32'hE);
    step();
    step();
    step();

    check_val("sb_msb_left", exp_q0.size(), 32'd0);
    check_val("sb_lsb_left", exp_q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
